// File: rtl/spare_alloc_decoder.sv
// Spare-PE allocation bitmap writer: decodes alloc/release commands into a one-hot
// select and maintains the availability mask. Optional macro: STICKY_ERR_EN.
module spare_alloc_decoder #(
    parameter int   OUTPUT_WIDTH = 4,
    parameter logic ENCODED_VAL  = 1'b0,
    localparam int  NUM_ENCODED_BITS = $clog2(OUTPUT_WIDTH),
    localparam int  CNT_BITS         = $clog2(OUTPUT_WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_op,
    input  logic [NUM_ENCODED_BITS-1:0] cmd_idx,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_err,
    output logic [OUTPUT_WIDTH-1:0]     decoded_out,
    output logic [OUTPUT_WIDTH-1:0]     mask_out,
    output logic [CNT_BITS-1:0]         free_count,
    output logic                        full
`ifdef STICKY_ERR_EN
    ,
    output logic                        err_sticky
`endif
);

    localparam logic OP_ALLOC   = 1'b0;
    localparam logic OP_RELEASE = 1'b1;
    localparam logic [NUM_ENCODED_BITS:0] W_EXT = (NUM_ENCODED_BITS + 1)'(OUTPUT_WIDTH);
    localparam logic [OUTPUT_WIDTH-1:0]   ONE   = {{(OUTPUT_WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                      state;
    logic                        cap_op;
    logic [NUM_ENCODED_BITS-1:0] cap_idx;
    logic [OUTPUT_WIDTH-1:0]     sel;
    logic                        idx_ok;
    logic                        sel_free;
    logic                        err;

    // An out-of-range index shifts the one-hot off the top, so sel is all zero.
    always_comb begin
        sel      = ONE << cap_idx;
        idx_ok   = {1'b0, cap_idx} < W_EXT;
        sel_free = ((|(mask_out & sel)) == ENCODED_VAL);
        err      = !idx_ok
                || (cap_op == OP_ALLOC   && !sel_free)
                || (cap_op == OP_RELEASE &&  sel_free);
    end

    assign full = (free_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cap_op      <= OP_ALLOC;
            cap_idx     <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            decoded_out <= '0;
            mask_out    <= {OUTPUT_WIDTH{ENCODED_VAL}};
            free_count  <= CNT_BITS'(OUTPUT_WIDTH);
`ifdef STICKY_ERR_EN
            err_sticky  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cap_op    <= cmd_op;
                        cap_idx   <= cmd_idx;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    if (!err) begin
                        mask_out    <= mask_out ^ sel;
                        free_count  <= sel_free ? free_count - CNT_BITS'(1)
                                                : free_count + CNT_BITS'(1);
                        decoded_out <= sel;
                    end else begin
                        decoded_out <= '0;
                    end
`ifdef STICKY_ERR_EN
                    if (err) err_sticky <= 1'b1;
`endif
                    state <= RESP;
                end
                RESP: begin
                    // Response fields stay frozen until the consumer takes them.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spare_alloc_decoder.sv
// Directed scoreboard bench for spare_alloc_decoder (W=4 main instance, W=6 range check).
module tb_spare_alloc_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_op = 1'b0, rsp_ready = 1'b1;
    logic [1:0] cmd_idx = '0;
    logic       cmd_ready, rsp_valid, rsp_err, full;
    logic [3:0] decoded_out, mask_out;
    logic [2:0] free_count;

    logic       c6_valid = 1'b0;
    logic [2:0] c6_idx = '0;
    logic       c6_ready, r6_valid, r6_err, full6;
    logic [5:0] dec6, mask6;
    logic [2:0] cnt6;
`ifdef STICKY_ERR_EN
    logic       err_sticky, err_sticky6;
`endif

    spare_alloc_decoder #(.OUTPUT_WIDTH(4), .ENCODED_VAL(1'b0)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_idx(cmd_idx), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_err(rsp_err), .decoded_out(decoded_out), .mask_out(mask_out),
        .free_count(free_count), .full(full)
`ifdef STICKY_ERR_EN
        , .err_sticky(err_sticky)
`endif
    );

    spare_alloc_decoder #(.OUTPUT_WIDTH(6), .ENCODED_VAL(1'b0)) dut6 (
        .clk(clk), .rst(rst), .cmd_valid(c6_valid), .cmd_ready(c6_ready),
        .cmd_op(1'b0), .cmd_idx(c6_idx), .rsp_valid(r6_valid), .rsp_ready(1'b1),
        .rsp_err(r6_err), .decoded_out(dec6), .mask_out(mask6),
        .free_count(cnt6), .full(full6)
`ifdef STICKY_ERR_EN
        , .err_sticky(err_sticky6)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       err;
        logic [3:0] dec;
        logic [3:0] mask;
        logic [2:0] cnt;
    } exp_t;

    exp_t       sbq[$];
    logic [3:0] m_mask = '0;
    int         m_cnt  = 4;
    int         total  = 0;
    int         bad    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_free(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i] == 1'b0) return i;
        return -1;
    endfunction

    // Drive one command, predict its response, then compare when rsp_valid appears.
    task automatic do_cmd(input logic op, input logic [1:0] idx, input bit hold);
        int   k;
        logic free_now, e_err;
        exp_t e, g;
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        chk("cmd_ready", 32'(cmd_ready), 32'd1);
        free_now = (m_mask[idx] == 1'b0);
        e_err    = (op == 1'b0) ? !free_now : free_now;
        if (!e_err) begin
            m_mask[idx] = ~m_mask[idx];
            m_cnt       = (op == 1'b0) ? m_cnt - 1 : m_cnt + 1;
        end
        e.err  = e_err;
        e.dec  = e_err ? 4'b0000 : (4'b0001 << idx);
        e.mask = m_mask;
        e.cnt  = 3'(m_cnt);
        sbq.push_back(e);
        cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        g = sbq.pop_front();
        chk("rsp_err",     32'(rsp_err),     32'(g.err));
        chk("decoded_out", 32'(decoded_out), 32'(g.dec));
        chk("mask_out",    32'(mask_out),    32'(g.mask));
        chk("free_count",  32'(free_count),  32'(g.cnt));
        chk("full",        32'(full),        32'(g.cnt == 3'd0));
        if (hold) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                cmd_valid = 1'b1; cmd_op = 1'b0; cmd_idx = 2'd0;
                @(negedge clk);
                chk("hold_rsp_valid", 32'(rsp_valid),   32'd1);
                chk("hold_decoded",   32'(decoded_out), 32'(g.dec));
                chk("hold_cmd_ready", 32'(cmd_ready),   32'd0);
                chk("hold_mask",      32'(mask_out),    32'(g.mask));
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("hold_release", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, cyc0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // reset state
        chk("rst_mask", 32'(mask_out), 32'h0);
        chk("rst_cnt",  32'(free_count), 32'd4);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_decoded", 32'(decoded_out), 32'h0);
`ifdef STICKY_ERR_EN
        chk("rst_sticky", 32'(err_sticky), 32'd0);
`endif
        // basic alloc, then encoder view of the mask
        do_cmd(1'b0, 2'd2, 1'b0);
        chk("enc_first_free", 32'(first_free(mask_out)), 32'd0);
        // double alloc and release of a free entry are rejected
        do_cmd(1'b0, 2'd2, 1'b0);
        do_cmd(1'b1, 2'd1, 1'b0);
`ifdef STICKY_ERR_EN
        chk("sticky_set", 32'(err_sticky), 32'd1);
`endif
        do_cmd(1'b1, 2'd2, 1'b0);
        // backpressure in RESP
        do_cmd(1'b0, 2'd3, 1'b1);
        do_cmd(1'b1, 2'd3, 1'b0);
        // fill all entries back-to-back
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        cyc0 = cyc;
        for (int i = 0; i < 4; i++) do_cmd(1'b0, 2'(i), 1'b0);
        @(negedge clk);
        chk("fill_cycles", 32'(cyc - cyc0), 32'd12);
        chk("fill_mask", 32'(mask_out), 32'hF);
        chk("fill_full", 32'(full), 32'd1);
        do_cmd(1'b0, 2'd0, 1'b0);
        // out-of-range index on the W=6 instance
        c6_valid = 1'b1; c6_idx = 3'd7;
        @(negedge clk);
        c6_valid = 1'b0;
        k = 0;
        while (!r6_valid && k < 20) begin @(negedge clk); k++; end
        chk("w6_rsp_valid", 32'(r6_valid), 32'd1);
        chk("w6_err",  32'(r6_err), 32'd1);
        chk("w6_dec",  32'(dec6),   32'h0);
        chk("w6_mask", 32'(mask6),  32'h0);
        chk("w6_cnt",  32'(cnt6),   32'd6);
        // reset during EXEC drops the command
        do_cmd(1'b1, 2'd1, 1'b0);
        k = 0;
        while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_idx = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_mask = '0; m_cnt = 4;
        repeat (2) @(negedge clk);
        chk("midrst_mask", 32'(mask_out), 32'h0);
        chk("midrst_cnt",  32'(free_count), 32'd4);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_full", 32'(full), 32'd0);
`ifdef STICKY_ERR_EN
        chk("midrst_sticky", 32'(err_sticky), 32'd0);
`endif
        do_cmd(1'b0, 2'd1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
